// File: rtl/gf180_ram_pkg.sv
// ============================================================
// gf180_ram_pkg: shared constants and types for gf180_ram_banked
// Rev 1.0
// ============================================================
`default_nettype none

package gf180_ram_pkg;

  localparam int MACRO_DEPTH = 256;
  localparam int MACRO_W     = 8;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_e;

  function automatic int bank_count(input int depth);
    return depth / MACRO_DEPTH;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gf180_ram_resp_fifo.sv
// ============================================================
// gf180_ram_resp_fifo: 2-entry response FIFO with registered head
// Rev 1.0
// ============================================================
`default_nettype none

module gf180_ram_resp_fifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [1:0]        o_count,
  output logic [DATA_W-1:0] o_head
);

  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [1:0]        r_count;
  logic              w_pop;
  logic              w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  // Head only changes on pop or when empty, so it holds under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head  <= i_data;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head <= i_data;
          end else if (w_push) begin
            r_tail  <= i_data;
            r_count <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_head <= r_tail;
            if (w_push) r_tail  <= i_data;
            else        r_count <= 2'd1;
          end
        end
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_head;

endmodule

`default_nettype wire

// File: rtl/gf180mcu_fd_ip_sram__sram256x8m8wm1.sv
// ============================================================
// gf180mcu_fd_ip_sram__sram256x8m8wm1: 256x8 bit-maskable SRAM macro model
// Rev 1.0
// ============================================================
`default_nettype none

module gf180mcu_fd_ip_sram__sram256x8m8wm1 (
  input  logic       CLK,
  input  logic       CEN,
  input  logic       GWEN,
  input  logic [7:0] WEN,
  input  logic [7:0] A,
  input  logic [7:0] D,
  output logic [7:0] Q
);

  logic [7:0] r_mem [256];
  logic [7:0] r_q;

  // Active-low controls; WEN masks individual bits, Q updates only on reads
  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        for (int i = 0; i < 8; i++) begin
          if (!WEN[i]) r_mem[A][i] <= D[i];
        end
      end else begin
        r_q <= r_mem[A];
      end
    end
  end

  assign Q = r_q;

endmodule

`default_nettype wire

// File: rtl/gf180_ram_banked.sv
// ============================================================
// gf180_ram_banked: banked GF180 SRAM array with valid/ready ports
// Optional clear-on-reset: GF180_RAM_CLEAR_ON_RESET_EN. Rev 1.0
// ============================================================
`default_nettype none

module gf180_ram_banked
  import gf180_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [AW-1:0]       req_addr,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata
);

  localparam int NB   = bank_count(DEPTH);
  localparam int NL   = DATA_W / MACRO_W;
  localparam int MA_W = $clog2(MACRO_DEPTH);
  localparam int BW   = (AW > MA_W) ? AW - MA_W : 1;

  logic [BW-1:0]               w_bank;
  logic                        w_accept;
  logic                        w_clearing;
  logic [MA_W-1:0]             w_clr_addr;
  logic [NB-1:0]               w_cen;
  logic [MA_W-1:0]             w_mac_addr;
  logic                        w_gwen;
  logic [NL-1:0][MACRO_W-1:0]  w_wen;
  logic [DATA_W-1:0]           w_mac_d;
  logic [NB-1:0][DATA_W-1:0]   w_bank_q;
  logic [DATA_W-1:0]           w_rd_data;
  logic                        r_inflight;
  logic [BW-1:0]               r_infl_bank;
  logic [1:0]                  w_fifo_count;
  logic                        w_pop;
  logic [2:0]                  w_pending;

  if (AW > MA_W) begin : g_bank_sel
    assign w_bank = req_addr[AW-1:MA_W];
  end else begin : g_bank_single
    assign w_bank = '0;
  end

`ifdef GF180_RAM_CLEAR_ON_RESET_EN
  clr_state_e      r_state;
  logic [MA_W-1:0] r_clr_addr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_addr <= r_clr_addr + 1'b1;
      if (r_clr_addr == '1) r_state <= RUN;
    end
  end

  assign w_clearing = (r_state == CLEAR);
  assign w_clr_addr = r_clr_addr;
`else
  assign w_clearing = 1'b0;
  assign w_clr_addr = '0;
`endif

  assign w_pop     = rsp_valid && rsp_ready;
  assign w_pending = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign req_ready = !w_clearing && (w_pending < 3'd2);
  assign w_accept  = req_valid && req_ready;

  assign w_mac_addr = w_clearing ? w_clr_addr : req_addr[MA_W-1:0];
  assign w_gwen     = w_clearing ? 1'b0 : !req_we;
  assign w_mac_d    = w_clearing ? '0 : req_wdata;

  always_comb begin
    for (int l = 0; l < NL; l++) begin
      w_wen[l] = 8'hFF;
      if (w_clearing || (req_we && req_be[l])) w_wen[l] = 8'h00;
    end
  end

  // Reset forces every macro idle, even while the clear FSM sits in CLEAR
  always_comb begin
    w_cen = '1;
    if (RST_N) begin
      for (int b = 0; b < NB; b++) begin
        if (w_clearing) begin
          w_cen[b] = 1'b0;
        end else if (w_accept && (w_bank == BW'(b)) && (!req_we || (req_be != '0))) begin
          w_cen[b] = 1'b0;
        end
      end
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    for (genvar l = 0; l < NL; l++) begin : g_lane
      gf180mcu_fd_ip_sram__sram256x8m8wm1 u_sram (
        .CLK  (CLK),
        .CEN  (w_cen[b]),
        .GWEN (w_gwen),
        .WEN  (w_wen[l]),
        .A    (w_mac_addr),
        .D    (w_mac_d[MACRO_W*l +: MACRO_W]),
        .Q    (w_bank_q[b][MACRO_W*l +: MACRO_W])
      );
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_inflight  <= 1'b0;
      r_infl_bank <= '0;
    end else begin
      r_inflight <= w_accept && !req_we;
      if (w_accept && !req_we) r_infl_bank <= w_bank;
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int b = 0; b < NB; b++) begin
      if (r_infl_bank == BW'(b)) w_rd_data = w_bank_q[b];
    end
  end

  gf180_ram_resp_fifo #(
    .DATA_W (DATA_W)
  ) u_resp_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .i_push  (r_inflight),
    .i_data  (w_rd_data),
    .i_pop   (w_pop),
    .o_count (w_fifo_count),
    .o_head  (rsp_rdata)
  );

  assign rsp_valid = (w_fifo_count != 2'd0);

endmodule

`default_nettype wire

// File: tb/tb_gf180_ram_banked.sv
// ============================================================
// tb_gf180_ram_banked: randomized bench with a behavioural memory model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_gf180_ram_banked;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int AW     = $clog2(DEPTH);
  localparam int NBE    = DATA_W / 8;
`ifdef GF180_RAM_CLEAR_ON_RESET_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we    = 1'b0;
  logic [AW-1:0]     req_addr  = '0;
  logic [NBE-1:0]    req_be    = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] mask;
    int                cyc;
  } rsp_t;

  rsp_t              rq[$];
  logic [DATA_W-1:0] m_mem   [DEPTH];
  bit   [NBE-1:0]    m_known [DEPTH];

  gf180_ram_banked #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tb_check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] byte_mask(input bit [NBE-1:0] k);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < NBE; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic model_reset();
    rq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = '0;
      m_known[i] = CLR_EN ? '1 : '0;
    end
  endtask

  // One clock of traffic: drive, check outputs against the model, advance the model
  task automatic step(input bit v, input bit we, input int a, input logic [NBE-1:0] be,
                      input logic [DATA_W-1:0] wd, input bit rr,
                      output bit acc, output bit vld, output logic [DATA_W-1:0] rd);
    bit   exp_valid;
    bit   exp_ready;
    bit   pop;
    int   pend;
    rsp_t item;
    @(negedge clk);
    req_valid = v;  req_we = we;  req_addr = AW'(a);
    req_be = be;    req_wdata = wd;  rsp_ready = rr;
    #1;
    exp_valid = 1'b0;
    if (rq.size() > 0) exp_valid = (cyc >= rq[0].cyc + 2);
    pop       = exp_valid && rr;
    pend      = rq.size() - (pop ? 1 : 0);
    exp_ready = (pend < 2);
    acc       = v && exp_ready;
    vld       = rsp_valid;
    rd        = rsp_rdata;
    tb_check("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
    tb_check("req_ready", 64'(req_ready), 64'(exp_ready));
    if (exp_valid && (rq[0].mask != '0))
      tb_check("rsp_rdata", 64'(rsp_rdata & rq[0].mask), 64'(rq[0].data & rq[0].mask));
    tb_check("cen_banks", 64'($countones(~dut.w_cen)), (acc && (!we || be != '0)) ? 64'd1 : 64'd0);
    if (pop) rq.delete(0);
    if (acc) begin
      if (we) begin
        for (int i = 0; i < NBE; i++) begin
          if (be[i]) begin
            m_mem[a][8*i +: 8] = wd[8*i +: 8];
            m_known[a][i]      = 1'b1;
          end
        end
      end else begin
        item.data = m_mem[a];
        item.mask = byte_mask(m_known[a]);
        item.cyc  = cyc;
        rq.push_back(item);
      end
    end
  endtask

  task automatic wr(input int a, input logic [DATA_W-1:0] d, input logic [NBE-1:0] be);
    bit acc, vld;
    logic [DATA_W-1:0] rd;
    int n;
    n = 0;
    do begin
      step(1'b1, 1'b1, a, be, d, 1'b1, acc, vld, rd);
      n++;
    end while (!acc && n < 20);
    tb_check("wr_accept", 64'(acc), 64'd1);
  endtask

  task automatic rd_one(input int a, output logic [DATA_W-1:0] data, output int lat);
    bit acc, vld;
    logic [DATA_W-1:0] rd;
    int n;
    n = 0;
    do begin
      step(1'b1, 1'b0, a, '0, '0, 1'b1, acc, vld, rd);
      n++;
    end while (!acc && n < 20);
    tb_check("rd_accept", 64'(acc), 64'd1);
    lat = 0;
    do begin
      step(1'b0, 1'b0, 0, '0, '0, 1'b1, acc, vld, rd);
      lat++;
    end while (!vld && lat < 20);
    data = rd;
  endtask

  task automatic check_in_reset();
    tb_check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    tb_check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    tb_check("rst_req_ready", 64'(req_ready), CLR_EN ? 64'd0 : 64'd1);
    tb_check("rst_cen_idle",  64'($countones(~dut.w_cen)), 64'd0);
  endtask

  // Called right after reset release on a falling edge
  task automatic wait_ready();
    int k;
    k = 0;
    #1;
    while (!req_ready && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    tb_check("ready_delay", 64'(k), CLR_EN ? 64'd256 : 64'd0);
  endtask

  initial begin
    bit                acc, vld;
    logic [DATA_W-1:0] rd, d;
    int                lat, n_acc, n_got, a;
    logic [DATA_W-1:0] got [4];

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_in_reset();
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready();

    wr(32'h155, 32'hDEADBEEF, 4'hF);
    rd_one(32'h155, d, lat);
    tb_check("basic_data", 64'(d), 64'hDEADBEEF);
    tb_check("basic_latency", 64'(lat), 64'd2);

    wr(5, 32'h11223344, 4'hF);
    wr(5, 32'hAABBCCDD, 4'b0101);
    rd_one(5, d, lat);
    tb_check("byte_mask", 64'(d), 64'h11BB33DD);
    wr(5, 32'hFFFFFFFF, 4'h0);
    rd_one(5, d, lat);
    tb_check("be_zero_noop", 64'(d), 64'h11BB33DD);

    wr(32'h0FF, 32'hCAFE00FF, 4'hF);
    wr(32'h100, 32'h0100BEEF, 4'hF);
    rd_one(32'h0FF, d, lat);
    tb_check("bank_lo", 64'(d), 64'hCAFE00FF);
    rd_one(32'h100, d, lat);
    tb_check("bank_hi", 64'(d), 64'h0100BEEF);

    // Backpressure: only two reads fit while the consumer stalls
    n_acc = 0;
    foreach (got[i]) begin
      a = (i == 0) ? 32'h155 : (i == 1) ? 5 : (i == 2) ? 32'h0FF : 32'h100;
      step(1'b1, 1'b0, a, '0, '0, 1'b0, acc, vld, rd);
      if (acc) n_acc++;
    end
    tb_check("bp_accepted", 64'(n_acc), 64'd2);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 0, '0, '0, 1'b0, acc, vld, rd);
      tb_check("bp_ready_low", 64'(req_ready), 64'd0);
      tb_check("bp_rdata_hold", 64'(rsp_rdata), 64'hDEADBEEF);
    end
    n_got = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 0, '0, '0, 1'b1, acc, vld, rd);
      if (vld && n_got < 4) begin
        got[n_got] = rd;
        n_got++;
      end
    end
    tb_check("bp_drain_count", 64'(n_got), 64'd2);
    tb_check("bp_order_0", 64'(got[0]), 64'hDEADBEEF);
    tb_check("bp_order_1", 64'(got[1]), 64'h11BB33DD);

    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, (i % 2 == 0) ? 32'h0FF : 32'h100, '0, '0, 1'b1, acc, vld, rd);
      if (acc) n_acc++;
    end
    tb_check("throughput", 64'(n_acc), 64'd6);
    repeat (4) step(1'b0, 1'b0, 0, '0, '0, 1'b1, acc, vld, rd);

    for (int i = 0; i < 800; i++) begin
      a = ($urandom_range(0, 3) << 8) |
          ($urandom_range(0, 1) ? (248 + $urandom_range(0, 7)) : $urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, NBE'($urandom),
           $urandom, $urandom_range(0, 3) != 0, acc, vld, rd);
    end
    repeat (4) step(1'b0, 1'b0, 0, '0, '0, 1'b1, acc, vld, rd);

    // Reset with two responses waiting in the buffer
    step(1'b1, 1'b0, 32'h0FF, '0, '0, 1'b0, acc, vld, rd);
    step(1'b1, 1'b0, 32'h100, '0, '0, 1'b0, acc, vld, rd);
    repeat (3) step(1'b0, 1'b0, 0, '0, '0, 1'b0, acc, vld, rd);
    tb_check("pre_rst_valid", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_in_reset();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready();
    repeat (5) step(1'b0, 1'b0, 0, '0, '0, 1'b1, acc, vld, rd);
    wr(32'h2A0, 32'h5A5AA5A5, 4'hF);
    rd_one(32'h2A0, d, lat);
    tb_check("post_rst_data", 64'(d), 64'h5A5AA5A5);

    if (CLR_EN) begin
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_in_reset();
      @(negedge clk);
      rst_n = 1'b1;
      wait_ready();
      for (int i = 0; i < DEPTH; i++)
        step(1'b1, 1'b0, i, '0, '0, 1'b1, acc, vld, rd);
      repeat (4) step(1'b0, 1'b0, 0, '0, '0, 1'b1, acc, vld, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
